ix_window_gen: RTL and testbench
================================

# ix_window_gen

Streaming window generator that sits upstream of the Ix derivative stage. It accepts a raster-order pixel stream over a val/rdy handshake, buffers the last `side-1` image rows in line buffers, and emits each complete `side` x `(side+2)` neighbourhood as a flattened 32-bit word array. The array matches exactly the input layout the Ix stage consumes. It handles frame wrap-around and backpressure, so the Ix stage can be driven straight from a camera-style pixel stream.

## Interface
- `side`, 3: window height; window width is `side+2`.
- `IMG_W`, 32: image width in pixels; must be ≥ `side+2`.
- `IMG_H`, 32: image height in pixels; must be ≥ `side`.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `in_msg`  in  32: pixel value, raster order (row 0 col 0 first).
- `in_val`  in  1: `in_msg` valid.
- `in_rdy`  out  1: block can accept a pixel this cycle.
- `image_out`  out  32 x `side*(side+2)`: window array, element `[j + i*(side+2)]` = row `i`, column `j`, both counted from the top-left of the window.
- `out_val`  out  1: `image_out` holds a valid window.
- `out_rdy`  in  1: consumer accepts the window this cycle.
- `out_last`  out  1: qualifies `out_val`; set on the final window of a frame.

## Operation
- Pixel transfer occurs when `in_val && in_rdy`. Window transfer occurs when `out_val && out_rdy`.
- `in_rdy = !out_val || out_rdy`. This is combinational, so an accepted pixel never overwrites an unconsumed window.
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) give the position of the next pixel to be accepted.
  - On each accepted pixel, `col` increments.
  - At `IMG_W-1`, `col` wraps to 0 and `row` increments.
  - At (`IMG_H-1`, `IMG_W-1`), both wrap to 0 and a new frame begins with no idle cycle.
- Line buffers: `side-1` rows of `IMG_W` words, indexed by `col`.
  - On an accepted pixel at column `c`, the column vector {linebuf[side-2][c], …, linebuf[0][c], in_msg} forms the new rightmost window column, oldest row on top.
  - The line buffers shift up by one row at column `c` only.
- Window register: `side` x `(side+2)`. On each accepted pixel, every row shifts left by one column and the new column vector enters column `side+1`.
- A window is complete after accepting the pixel at (r, c) with `r ≥ side-1` and `c ≥ side+1`.
  - Element `[j + i*(side+2)]` = pixel(r-side+1+i, c-side-1+j).
  - Windows spanning a row boundary are never emitted, because the column gate excludes them.
  - Stale line-buffer data from the previous frame is never emitted, because the row gate excludes it.
- Windows per frame = `(IMG_H-side+1)*(IMG_W-side-1)`.
- `out_last` is set with the window completed at (`IMG_H-1`, `IMG_W-1`).
- Output register behaviour:
  - When a pixel completes a window, the window is loaded into `image_out` and `out_val` is set.
  - Otherwise, if the current window transfers, `out_val` and `out_last` clear.
  - `image_out` holds its value until the next load.
- Pixel values are passed through unmodified. No arithmetic is performed on data.

## Timing
- Reset values:
  - `out_val` = 0, `out_last` = 0, `image_out` all 0, `row` = `col` = 0.
  - `in_rdy` = 1 in the first cycle after reset.
  - Line buffers and window register are not reset; their contents are don't-care because of the gating.
- Latency: a window is presented with `out_val` high in the cycle after its completing pixel is accepted.
- Throughput: one pixel per cycle. Windows stream back-to-back when `out_rdy` is held high.
- Simultaneous pixel accept, window transfer and new window load in one cycle is legal. In that case `out_val` stays high with the new window.
- While `out_val && !out_rdy`, `in_rdy` = 0. No state changes and `image_out`/`out_last` stay stable.
- `in_val` deasserted is a bubble: no counter, buffer or window change.
- `reset` asserted mid-frame:
  - The partial frame is discarded and any pending window is dropped.
  - Counters return to 0 and the next accepted pixel is (0, 0) of a new frame.

## Test plan
- Single frame, IMG_W=8, IMG_H=5, side=3, pixel = r*8+c, `out_rdy`=1 → exactly 12 windows.
  - First window appears the cycle after pixel 20 is accepted: `image_out[0]`=0, `[4]`=4, `[5]`=8, `[14]`=20.
  - Last window has `[14]`=39 and `out_last`=1. `out_last` is 0 on all other windows.
- Same stimulus with the Ix stage attached → every Ix output element equals 2.
- Backpressure: hold `out_rdy`=0 for 5 cycles at the first window → `in_rdy`=0 and `image_out` stays stable throughout. Then release → window transfers once, and all 12 windows still arrive in order with none duplicated.
- Random `in_val` bubbles and random `out_rdy` over 3 back-to-back frames → 36 windows, each matching the golden model. No window mixes pixels from two frames.
- Reset pulse after pixel 25 of frame 1, then a full frame with pixel = 100+r*8+c → 12 windows, first `[0]`=100. No window contains values below 100.
- After reset with no input → `out_val`=0, `in_rdy`=1, `image_out` all 0.

Source files
------------

// File: rtl/ix_window_gen.sv
// ix_window_gen: streaming window generator feeding the Ix derivative stage.
// Buffers the last side-1 image rows and presents every complete
// side x (side+2) neighbourhood of a raster-order pixel stream as a flat
// word array, with val/rdy handshakes on both sides and frame wrap-around.
module ix_window_gen #(
  parameter int side  = 3,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_msg,
  input  logic        in_val,
  output logic        in_rdy,
  output logic [31:0] image_out [side*(side+2)],
  output logic        out_val,
  input  logic        out_rdy,
  output logic        out_last
);

  localparam int WIN_W = side + 2;
  localparam int NWORD = side * WIN_W;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_GATE = CW'(side + 1);
  localparam logic [RW-1:0] ROW_GATE = RW'(side - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // linebuf[0] holds the previous row, linebuf[side-2] the oldest buffered row.
  logic [31:0] linebuf  [side-1][IMG_W];
  logic [31:0] win      [side][WIN_W];
  logic [31:0] next_win [side][WIN_W];
  logic [31:0] col_vec  [side];

  logic accept;
  logic complete;
  logic frame_end;

  // A pixel may enter only when no unconsumed window would be overwritten.
  assign in_rdy    = !out_val || out_rdy;
  assign accept    = in_val && in_rdy;
  assign complete  = accept && (row >= ROW_GATE) && (col >= COL_GATE);
  assign frame_end = (row == ROW_MAX) && (col == COL_MAX);

  // Column entering the window: buffered rows oldest on top, live pixel at the bottom.
  always_comb begin
    // NOTE: every element gets an assignment on every pass, so no latch is inferred.
    for (int i = 0; i < side - 1; i++) begin
      col_vec[i] = linebuf[side-2-i][col];
    end
    col_vec[side-1] = in_msg;
  end

  // Window contents after the current pixel: shift left, new column on the right.
  always_comb begin
    for (int i = 0; i < side; i++) begin
      for (int j = 0; j < WIN_W - 1; j++) begin
        next_win[i][j] = win[i][j+1];
      end
      next_win[i][WIN_W-1] = col_vec[i];
    end
  end

  // Raster position of the next pixel to be accepted; wraps at frame end.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Line buffers shift up one row at the current column only.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are deliberately unreset; the row/column gates hide stale data.
    if (accept) begin
      linebuf[0][col] <= in_msg;
      for (int k = 1; k < side - 1; k++) begin
        linebuf[k][col] <= linebuf[k-1][col];
      end
    end
  end

  // Sliding window register advances on every accepted pixel.
  always_ff @(posedge clk) begin
    if (accept) begin
      win <= next_win;
    end
  end

  // Output register: load on a completed window, clear valid once consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_val  <= 1'b0;
      out_last <= 1'b0;
      for (int n = 0; n < NWORD; n++) begin
        image_out[n] <= '0;
      end
    end else if (complete) begin
      out_val  <= 1'b1;
      out_last <= frame_end;
      for (int i = 0; i < side; i++) begin
        for (int j = 0; j < WIN_W; j++) begin
          image_out[j + i*WIN_W] <= next_win[i][j];
        end
      end
    end else if (out_val && out_rdy) begin
      out_val  <= 1'b0;
      out_last <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ix_window_gen.sv
// Directed bench for ix_window_gen at side=3, 8x5 image: streaming, latency,
// backpressure, random bubbles over back-to-back frames and mid-frame reset.
module tb_ix_window_gen;

  localparam int SIDE  = 3;
  localparam int W     = 8;
  localparam int H     = 5;
  localparam int NWORD = SIDE * (SIDE + 2);
  localparam int NPIX  = W * H;
  localparam int WPR   = W - SIDE - 1;
  localparam int WPF   = (H - SIDE + 1) * WPR;
  localparam int FW    = 32 * NWORD;

  logic        clk;
  logic        reset;
  logic [31:0] in_msg;
  logic        in_val;
  logic        in_rdy;
  logic [31:0] img [NWORD];
  logic        out_val;
  logic        out_rdy;
  logic        out_last;

  int vectors     = 0;
  int miscompares = 0;
  int pix_sent    = 0;
  int win_got     = 0;
  int frame_base [8] = '{0, 1000, 2000, 3000, 4000, 5000, 6000, 7000};

  ix_window_gen #(.side(SIDE), .IMG_W(W), .IMG_H(H)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_msg   (in_msg),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .image_out(img),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [FW-1:0] flat_img();
    logic [FW-1:0] f;
    for (int n = 0; n < NWORD; n++) f[n*32 +: 32] = img[n];
    return f;
  endfunction

  // Pixel value of the p-th accepted pixel since reset: frame base + r*W + c.
  function automatic logic [31:0] pixval(input int p);
    return 32'(frame_base[(p / NPIX) % 8] + (p % NPIX));
  endfunction

  // Expected w-th window since reset, completed at (r, c).
  function automatic logic [FW-1:0] exp_window(input int w);
    logic [FW-1:0] e;
    int f, k, r, c;
    f = (w / WPF) % 8;
    k = w % WPF;
    r = SIDE - 1 + k / WPR;
    c = SIDE + 1 + k % WPR;
    for (int i = 0; i < SIDE; i++)
      for (int j = 0; j < SIDE + 2; j++)
        e[(j + i*(SIDE+2))*32 +: 32] =
          32'(frame_base[f] + (r - SIDE + 1 + i) * W + (c - SIDE - 1 + j));
    return e;
  endfunction

  // One clock: drive inputs, check any window transferring this cycle, advance.
  task automatic tick(input logic v, input logic r);
    logic acc, xfer;
    in_val  = v;
    out_rdy = r;
    in_msg  = pixval(pix_sent);
    #1;
    acc  = in_val && in_rdy;
    xfer = out_val && out_rdy;
    if (xfer) begin
      chk($sformatf("win%0d", win_got), flat_img(), exp_window(win_got));
      chk($sformatf("last%0d", win_got), FW'(out_last), FW'((win_got % WPF) == WPF - 1));
      win_got++;
    end
    if (acc) pix_sent++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int target);
    int n = 0;
    while (win_got < target && n < 500) begin
      tick(1'b0, 1'b1);
      n++;
    end
    chk($sformatf("count_to_%0d", target), FW'(win_got), FW'(target));
  endtask

  task automatic do_reset(input int base0);
    reset  = 1'b1;
    in_val = 1'b0;
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    pix_sent = 0;
    win_got  = 0;
    frame_base[0] = base0;
  endtask

  initial begin
    int n;
    logic [FW-1:0] snap;
    reset   = 1'b1;
    in_val  = 1'b0;
    in_msg  = '0;
    out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_out_val", FW'(out_val), FW'(0));
    chk("rst_out_last", FW'(out_last), FW'(0));
    chk("rst_in_rdy", FW'(in_rdy), FW'(1));
    chk("rst_image", flat_img(), '0);

    // Frame 0: plain streaming, first-window latency and contents
    for (int p = 0; p < 20; p++) tick(1'b1, 1'b1);
    chk("no_win_before_px20", FW'(out_val), FW'(0));
    tick(1'b1, 1'b1);
    chk("win_after_px20", FW'(out_val), FW'(1));
    chk("first_e0", FW'(img[0]), FW'(0));
    chk("first_e4", FW'(img[4]), FW'(4));
    chk("first_e5", FW'(img[5]), FW'(8));
    chk("first_e14", FW'(img[14]), FW'(20));
    for (int p = 21; p < NPIX; p++) tick(1'b1, 1'b1);
    drain(WPF);

    // Frame 1: backpressure held for 5 cycles on the first window
    n = 0;
    while (!out_val && n < 200) begin
      tick(1'b1, 1'b1);
      n++;
    end
    chk("bp_window_seen", FW'(out_val), FW'(1));
    snap = flat_img();
    for (int s = 0; s < 5; s++) begin
      tick(1'b1, 1'b0);
      chk($sformatf("bp_in_rdy%0d", s), FW'(in_rdy), FW'(0));
      chk($sformatf("bp_val%0d", s), FW'(out_val), FW'(1));
      chk($sformatf("bp_stable%0d", s), flat_img(), snap);
    end
    chk("bp_no_extra_px", FW'(pix_sent), FW'(NPIX + 21));
    while (pix_sent < 2 * NPIX) tick(1'b1, 1'b1);
    drain(2 * WPF);

    // Frames 2..4: random input bubbles and random consumer stalls
    n = 0;
    while (win_got < 5 * WPF && n < 3000) begin
      tick((pix_sent < 5 * NPIX) && ($urandom_range(0, 3) != 0), $urandom_range(0, 2) != 0);
      n++;
    end
    chk("rand_count", FW'(win_got), FW'(5 * WPF));
    chk("rand_all_px", FW'(pix_sent), FW'(5 * NPIX));

    // Partial frame 5 (26 pixels), then reset mid-frame
    for (int p = 0; p < 26; p++) tick(1'b1, 1'b1);
    chk("partial_windows", FW'(win_got), FW'(5 * WPF + 4));
    do_reset(100);
    chk("midrst_out_val", FW'(out_val), FW'(0));
    chk("midrst_in_rdy", FW'(in_rdy), FW'(1));
    for (int p = 0; p < NPIX; p++) tick(1'b1, 1'b1);
    drain(WPF);

    // Idle after reset
    do_reset(0);
    repeat (3) tick(1'b0, 1'b0);
    chk("idle_out_val", FW'(out_val), FW'(0));
    chk("idle_in_rdy", FW'(in_rdy), FW'(1));
    chk("idle_image", flat_img(), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
